regfile_sequencer: RTL and testbench



---
 rtl/regfile_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_sequencer
//
// Command sequencer placed in front of an 8 x 8-bit register file that has a
// single read port and a single write port. It accepts one register-transfer
// command at a time over a valid/ready handshake and executes it. Supported
// commands are LDI, MOV, ADD and SUB. It reports the written value and the
// carry/zero flags, and it raises a one-cycle completion pulse.
//
// Every read occupies two cycles: a select cycle and a capture cycle. A
// register file with a combinational read port works with this, and so does
// one with a single-cycle registered read port.
//
// Ports
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   cmd_valid    in   1  command present
//   cmd_ready    out  1  sequencer idle and able to accept (combinational)
//   cmd_op       in   2  00 LDI, 01 MOV, 10 ADD, 11 SUB
//   cmd_dst      in   3  destination register, also operand A for ADD/SUB
//   cmd_src      in   3  source register, operand B for MOV/ADD/SUB
//   cmd_imm      in   8  immediate value for LDI
//   rf_read_sel  out  3  register file read select
//   rf_write_sel out  3  register file write select
//   rf_write_en  out  1  register file write enable (one cycle per command)
//   rf_data_in   out  8  register file write data
//   rf_data_out  in   8  register file read data
//   result       out  8  last value written
//   carry        out  1  ADD carry-out / SUB borrow (held across LDI/MOV)
//   zero         out  1  last written value was zero
//   done         out  1  one-cycle pulse in the first idle cycle after a write
// ---------------------------------------------------------------------------
module regfile_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_dst,
    input  logic [2:0] cmd_src,
    input  logic [7:0] cmd_imm,
    output logic [2:0] rf_read_sel,
    output logic [2:0] rf_write_sel,
    output logic       rf_write_en,
    output logic [7:0] rf_data_in,
    input  logic [7:0] rf_data_out,
    output logic [7:0] result,
    output logic       carry,
    output logic       zero,
    output logic       done
);

    // Command encodings
    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // Sequencer states
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_A_SEL = 3'd1;
    localparam logic [2:0] S_A_CAP = 3'd2;
    localparam logic [2:0] S_B_SEL = 3'd3;
    localparam logic [2:0] S_B_CAP = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;

    // ALU: returns {carry, value}. MOV passes operand B through. For SUB,
    // the flag bit is the borrow, which is set when a < b.
    function automatic logic [8:0] alu_f(
        input logic [1:0] op,
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [8:0] v;
        v = 9'd0;
        case (op)
            OP_ADD:  v = {1'b0, a} + {1'b0, b};
            OP_SUB:  v = {(a < b), 8'(a - b)};
            OP_MOV:  v = {1'b0, b};
            default: v = {1'b0, b};
        endcase
        return v;
    endfunction

    // State and latched command
    logic [2:0] r_state;
    logic [1:0] r_op;
    logic [2:0] r_dst;
    logic [2:0] r_src;
    logic [7:0] r_op_a;
    logic       r_carry_pend;

    // Registered outputs
    logic [2:0] r_rd_sel;
    logic [2:0] r_wr_sel;
    logic       r_wr_en;
    logic [7:0] r_wr_data;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_zero;
    logic       r_done;

    // Combinational helpers
    logic       w_accept;
    logic [2:0] w_state_next;
    logic [8:0] w_alu;

    assign cmd_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = cmd_valid && cmd_ready;

    // Operand B is consumed at the capture edge directly from the read
    // port, so it does not need a register of its own.
    assign w_alu = alu_f(r_op, r_op_a, rf_data_out);

    // Next-state selection
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_LDI:  w_state_next = S_WRITE;
                        OP_MOV:  w_state_next = S_B_SEL;
                        default: w_state_next = S_A_SEL;
                    endcase
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_A_SEL: w_state_next = S_A_CAP;
            S_A_CAP: w_state_next = S_B_SEL;
            S_B_SEL: w_state_next = S_B_CAP;
            S_B_CAP: w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch, operand capture and register-file port drive
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op         <= 2'd0;
            r_dst        <= 3'd0;
            r_src        <= 3'd0;
            r_op_a       <= 8'd0;
            r_carry_pend <= 1'b0;
            r_rd_sel     <= 3'd0;
            r_wr_sel     <= 3'd0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd_op;
                        r_dst <= cmd_dst;
                        r_src <= cmd_src;
                        case (cmd_op)
                            // LDI needs no reads, so the write goes out on the next cycle
                            OP_LDI: begin
                                r_wr_en   <= 1'b1;
                                r_wr_sel  <= cmd_dst;
                                r_wr_data <= cmd_imm;
                            end
                            OP_MOV:  r_rd_sel <= cmd_src;
                            default: r_rd_sel <= cmd_dst;
                        endcase
                    end
                end
                S_A_CAP: begin
                    r_op_a   <= rf_data_out;
                    r_rd_sel <= r_src;
                end
                S_B_CAP: begin
                    // The ALU result is registered into the write port here.
                    // The carry is held back until the write completes.
                    r_wr_en      <= 1'b1;
                    r_wr_sel     <= r_dst;
                    r_wr_data    <= w_alu[7:0];
                    r_carry_pend <= w_alu[8];
                end
                S_WRITE: begin
                    r_wr_en <= 1'b0;
                end
                default: begin
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    // Result, flags and completion pulse, all updated as the write completes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= 8'd0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= (r_state == S_WRITE);
            if (r_state == S_WRITE) begin
                r_result <= r_wr_data;
                r_zero   <= (r_wr_data == 8'd0);
                // LDI and MOV leave the carry flag untouched
                if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
                    r_carry <= r_carry_pend;
                end
            end
        end
    end

    assign rf_read_sel  = r_rd_sel;
    assign rf_write_sel = r_wr_sel;
    assign rf_write_en  = r_wr_en;
    assign rf_data_in   = r_wr_data;
    assign result       = r_result;
    assign carry        = r_carry;
    assign zero         = r_zero;
    assign done         = r_done;

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_dst;
    logic [2:0] cmd_src;
    logic [7:0] cmd_imm;
    logic [2:0] rf_read_sel;
    logic [2:0] rf_write_sel;
    logic       rf_write_en;
    logic [7:0] rf_data_in;
    logic [7:0] rf_data_out;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       done;

    int total = 0;
    int bad   = 0;
    int wen_total = 0;

    // Behavioural 8 x 8 register file: combinational read, write on the rising edge
    logic [7:0] mem [8] = '{default: 8'h00};
    assign rf_data_out = mem[rf_read_sel];
    always @(posedge clk) begin
        if (rf_write_en === 1'b1) begin
            mem[rf_write_sel] <= rf_data_in;
            wen_total = wen_total + 1;
        end
    end

    always #5 clk = ~clk;

    regfile_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dst      (cmd_dst),
        .cmd_src      (cmd_src),
        .cmd_imm      (cmd_imm),
        .rf_read_sel  (rf_read_sel),
        .rf_write_sel (rf_write_sel),
        .rf_write_en  (rf_write_en),
        .rf_data_in   (rf_data_in),
        .rf_data_out  (rf_data_out),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command and wait for it to be accepted. On return, the time
    // is 1 time unit after the accept edge (cycle 1).
    task automatic send(input logic [1:0] op, input logic [2:0] dst,
                        input logic [2:0] src, input logic [7:0] imm);
        bit acc;
        acc = 1'b0;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_imm = imm;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            if (cmd_ready === 1'b1) acc = 1'b1;
            step();
        end
        cmd_valid = 1'b0;
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Run one command and record the write cycle, write port values, done cycle and write count
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst,
                           input logic [2:0] src, input logic [7:0] imm,
                           output int wen_c, output int wsel, output int wdat,
                           output int done_c, output int nwr);
        wen_c = 0; wsel = 0; wdat = 0; done_c = 0; nwr = 0;
        send(op, dst, src, imm);
        for (int k = 1; k <= 12; k++) begin
            if (rf_write_en === 1'b1) begin
                nwr = nwr + 1;
                if (wen_c == 0) begin
                    wen_c = k; wsel = int'(rf_write_sel); wdat = int'(rf_data_in);
                end
            end
            if (done === 1'b1) begin
                done_c = k;
                break;
            end
            step();
        end
        if (done_c == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int wc, ws, wd, dc, nw, snap;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
        cmd_dst = 3'd0; cmd_src = 3'd0; cmd_imm = 8'd0;
        step(); step();
        chk("rst_ready",  32'(cmd_ready), 32'd0);
        chk("rst_outs",   {rf_read_sel, rf_write_sel, rf_write_en, rf_data_in,
                           result, carry, zero, done}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // LDI r5, 9
        run_cmd(2'b00, 3'd5, 3'd0, 8'd9, wc, ws, wd, dc, nw);
        chk("ldi_wen_cyc", wc, 1);
        chk("ldi_wsel",    ws, 5);
        chk("ldi_wdat",    wd, 9);
        chk("ldi_done",    dc, 2);
        chk("ldi_nwr",     nw, 1);
        chk("ldi_flags",   {result, carry, zero}, {8'd9, 1'b0, 1'b0});

        // LDI r1,200; LDI r2,100; ADD r1,r2
        run_cmd(2'b00, 3'd1, 3'd0, 8'd200, wc, ws, wd, dc, nw);
        run_cmd(2'b00, 3'd2, 3'd0, 8'd100, wc, ws, wd, dc, nw);
        chk("ldi2_result", result, 100);
        run_cmd(2'b10, 3'd1, 3'd2, 8'd0, wc, ws, wd, dc, nw);
        chk("add_wen_cyc", wc, 5);
        chk("add_wsel",    ws, 1);
        chk("add_wdat",    wd, 44);
        chk("add_done",    dc, 6);
        chk("add_flags",   {result, carry, zero}, {8'd44, 1'b1, 1'b0});
        chk("add_mem_r1",  mem[1], 44);

        // SUB r2,r2 -> 0
        run_cmd(2'b11, 3'd2, 3'd2, 8'd0, wc, ws, wd, dc, nw);
        chk("subrr_flags", {result, carry, zero}, {8'd0, 1'b0, 1'b1});
        chk("subrr_mem",   mem[2], 0);

        // SUB r5(9), r1(44) -> 221 with borrow
        run_cmd(2'b11, 3'd5, 3'd1, 8'd0, wc, ws, wd, dc, nw);
        chk("sub_flags",   {result, carry, zero}, {8'd221, 1'b1, 1'b0});
        chk("sub_mem_r5",  mem[5], 221);

        // MOV r6, r5 leaves the carry set
        run_cmd(2'b01, 3'd6, 3'd5, 8'd0, wc, ws, wd, dc, nw);
        chk("mov_wen_cyc", wc, 3);
        chk("mov_done",    dc, 4);
        chk("mov_flags",   {result, carry, zero}, {8'd221, 1'b1, 1'b0});
        chk("mov_mem_r6",  mem[6], 221);

        // ADD r3(0), r6(221) while cmd_valid stays high and cmd_dst keeps changing
        cmd_op = 2'b10; cmd_dst = 3'd3; cmd_src = 3'd6; cmd_valid = 1'b1;
        step();
        nw = 0; ws = 0;
        for (int k = 1; k <= 5; k++) begin
            chk("busy_ready", 32'(cmd_ready), 32'd0);
            if (rf_write_en === 1'b1) begin nw = nw + 1; ws = int'(rf_write_sel); end
            cmd_dst = 3'(k);
            step();
        end
        chk("hold_nwr",   nw, 1);
        chk("hold_wsel",  ws, 3);
        chk("hold_done",  32'(done), 32'd1);
        chk("hold_ready", 32'(cmd_ready), 32'd1);
        chk("hold_flags", {result, carry, zero}, {8'd221, 1'b0, 1'b0});
        // The command presented during the done cycle is LDI r7, 77
        cmd_op = 2'b00; cmd_dst = 3'd7; cmd_imm = 8'd77;
        step();
        cmd_valid = 1'b0;
        chk("b2b_wport", {rf_write_en, rf_write_sel, rf_data_in}, {1'b1, 3'd7, 8'd77});
        step();
        chk("b2b_done",  {done, result, carry}, {1'b1, 8'd77, 1'b0});
        chk("hold_mem3", mem[3], 221);

        // Reset asserted during B_CAP of ADD r1, r2
        send(2'b10, 3'd1, 3'd2, 8'd0);
        step(); step(); step();
        chk("bcap_rdsel", rf_read_sel, 2);
        snap = wen_total;
        reset = 1'b1;
        step();
        chk("abort_outs", {rf_read_sel, rf_write_sel, rf_write_en, rf_data_in,
                           result, carry, zero, done}, 32'd0);
        chk("abort_ready_rst", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        step(); step(); step();
        chk("abort_nowrite", wen_total, snap);
        chk("abort_mem_r1",  mem[1], 44);
        chk("abort_done",    32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
